// File: rtl/fft_pkg.sv
// Shared types for the FFT output serializer: FSM state encoding and index-width helper.
package fft_pkg;

  typedef enum logic {FS_IDLE, FS_STREAM} fft_ser_state_t;

  function automatic int bin_idx_w(input int samples);
    return $clog2(samples);
  endfunction

endpackage

// File: rtl/fft_bin_serializer.sv
// Captures a parallel FFT bin vector on fft_valid and streams it one bin per valid/ready beat.
// Build option FFT_SER_HALF_EN: emit only bins 0..SAMPLES/2 (real-input spectrum symmetry).
//
// state     | meaning
// FS_IDLE   | no frame held, waiting for fft_valid
// FS_STREAM | frame buffered, beats presented on bin_* until the last one is accepted
module fft_bin_serializer
  import fft_pkg::*;
#(
  parameter int SAMPLES = 16,
  parameter int WIDTH   = 32,
  parameter int DROP_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fft_valid,
  input  logic [WIDTH-1:0]              fft_bins [SAMPLES],
  output logic                          bin_valid,
  input  logic                          bin_ready,
  output logic [WIDTH-1:0]              bin_data,
  output logic [bin_idx_w(SAMPLES)-1:0] bin_index,
  output logic                          bin_last,
  output logic                          busy,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int IDX_W = bin_idx_w(SAMPLES);
`ifdef FFT_SER_HALF_EN
  localparam int LAST_IDX = SAMPLES / 2;
`else
  localparam int LAST_IDX = SAMPLES - 1;
`endif
  localparam int BUF_N = LAST_IDX + 1;
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(LAST_IDX);

  fft_ser_state_t   state;
  logic [WIDTH-1:0] frame_buf [BUF_N];
  logic             accept;
  logic             accept_last;
  logic             capture;
  logic             drop;
  logic [IDX_W-1:0] idx_next;

  // A frame arriving on the cycle the last beat leaves is accepted, not dropped.
  always_comb begin
    accept      = bin_valid & bin_ready;
    accept_last = accept & bin_last;
    capture     = fft_valid & ((state == FS_IDLE) | accept_last);
    drop        = fft_valid & (state == FS_STREAM) & ~accept_last;
    idx_next    = bin_index + 1'b1;
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < BUF_N; i++) begin
        frame_buf[i] <= fft_bins[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FS_IDLE;
      bin_valid  <= 1'b0;
      bin_data   <= '0;
      bin_index  <= '0;
      bin_last   <= 1'b0;
      busy       <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end

      if (capture) begin
        state     <= FS_STREAM;
        bin_valid <= 1'b1;
        busy      <= 1'b1;
        bin_index <= '0;
        bin_data  <= fft_bins[0];
        bin_last  <= 1'b0;
      end else begin
        case (state)
          FS_IDLE: begin
            bin_valid <= 1'b0;
            busy      <= 1'b0;
          end
          FS_STREAM: begin
            if (accept_last) begin
              state     <= FS_IDLE;
              bin_valid <= 1'b0;
              busy      <= 1'b0;
              bin_last  <= 1'b0;
              bin_index <= '0;
            end else if (accept) begin
              bin_index <= idx_next;
              bin_data  <= frame_buf[idx_next];
              bin_last  <= (idx_next == LAST_I);
            end
          end
          default: state <= FS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Self-checking bench for fft_bin_serializer: frame table plus hand-written corner sequences.
module tb_fft_bin_serializer;

  localparam int SAMPLES = 16;
  localparam int WIDTH   = 32;
`ifdef FFT_SER_HALF_EN
  localparam int LAST    = 8;
  localparam int RST_IDX = 5;
`else
  localparam int LAST    = 15;
  localparam int RST_IDX = 9;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  typedef struct {
    int offset;
    int stall_idx;
    int stall_len;
    int exp_cycles;
  } frame_vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fft_valid = 1'b0;
  logic             bin_ready = 1'b0;
  logic [WIDTH-1:0] fft_bins [SAMPLES];

  logic             bin_valid, bin_last, busy;
  logic [WIDTH-1:0] bin_data;
  logic [3:0]       bin_index;
  logic [7:0]       drop_count;

  logic             s_valid, s_last, s_busy;
  logic [WIDTH-1:0] s_data;
  logic [3:0]       s_index;
  logic [1:0]       s_drop;

  int    total = 0;
  int    passed = 0;
  beat_t sb [$];
  beat_t exp_b;
  logic  prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_idx;

  always #5 clk = ~clk;

  fft_bin_serializer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH), .DROP_W(8)) u_dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_bins(fft_bins),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_data(bin_data),
    .bin_index(bin_index), .bin_last(bin_last), .busy(busy), .drop_count(drop_count)
  );

  fft_bin_serializer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH), .DROP_W(2)) u_sat (
    .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_bins(fft_bins),
    .bin_valid(s_valid), .bin_ready(bin_ready), .bin_data(s_data),
    .bin_index(s_index), .bin_last(s_last), .busy(s_busy), .drop_count(s_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_bins(input int offset);
    for (int k = 0; k < SAMPLES; k++) fft_bins[k] = 32'(k * 100 + offset);
  endtask

  task automatic load_frame(input int offset, input bit push);
    set_bins(offset);
    fft_valid = 1'b1;
    if (push) begin
      for (int k = 0; k <= LAST; k++) sb.push_back('{32'(k * 100 + offset), 4'(k), (k == LAST)});
    end
    @(posedge clk); #1;
    fft_valid = 1'b0;
  endtask

  task automatic wait_idx(input int target);
    bit found = 0;
    for (int n = 0; n < 100; n++) begin
      if (bin_valid && int'(bin_index) == target) begin found = 1; break; end
      @(posedge clk); #1;
    end
    check("wait_idx_timeout", 32'(found), 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input int offset, input int stall_idx, input int stall_len,
                           output int cycles);
    int rem;
    rem = stall_len;
    cycles = 0;
    bin_ready = 1'b1;
    load_frame(offset, 1'b1);
    check("latency_valid", 32'(bin_valid), 32'd1);
    check("latency_index", 32'(bin_index), 32'd0);
    for (int n = 0; n < 200; n++) begin
      if (!busy) break;
      if (rem > 0 && int'(bin_index) == stall_idx) begin
        bin_ready = 1'b0;
        rem--;
        check("stall_data", bin_data, 32'(stall_idx * 100 + offset));
      end else begin
        bin_ready = 1'b1;
      end
      cycles++;
      @(posedge clk); #1;
    end
    bin_ready = 1'b1;
  endtask

  // Beat monitor: outputs are stable mid-cycle; valid&ready here means a transfer at the next edge.
  always @(negedge clk) begin
    if (rst && bin_valid) begin
      check("last_flag", 32'(bin_last), 32'(int'(bin_index) == LAST));
      if (prev_stall) begin
        check("hold_data", bin_data, prev_data);
        check("hold_index", 32'(bin_index), 32'(prev_idx));
      end
      if (bin_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_b = sb.pop_front();
          check("beat_data", bin_data, exp_b.data);
          check("beat_index", 32'(bin_index), 32'(exp_b.idx));
          check("beat_last", 32'(bin_last), 32'(exp_b.last));
        end
      end
    end
    prev_stall = rst && bin_valid && !bin_ready;
    prev_data  = bin_data;
    prev_idx   = bin_index;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    frame_vec_t vecs [4];
    int cycles;
    vecs[0] = '{0, -1, 0, LAST + 1};
    vecs[1] = '{0, 5, 3, LAST + 4};
    vecs[2] = '{7, 0, 2, LAST + 3};
    vecs[3] = '{3, LAST, 1, LAST + 2};

    set_bins(0);
    #12;
    check("rst_valid", 32'(bin_valid), 32'd0);
    check("rst_last", 32'(bin_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", bin_data, 32'd0);
    check("rst_index", 32'(bin_index), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bin_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_valid", 32'(bin_valid), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].offset, vecs[i].stall_idx, vecs[i].stall_len, cycles);
      check("frame_cycles", 32'(cycles), 32'(vecs[i].exp_cycles));
      check("frame_drop", 32'(drop_count), 32'd0);
      @(posedge clk); #1;
    end

    // Back-to-back: new frame strobed on the cycle the last beat is accepted.
    bin_ready = 1'b1;
    load_frame(0, 1'b1);
    wait_idx(LAST);
    load_frame(1, 1'b1);
    check("b2b_valid", 32'(bin_valid), 32'd1);
    check("b2b_index", 32'(bin_index), 32'd0);
    check("b2b_data", bin_data, 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_idle();
    check("b2b_drop", 32'(drop_count), 32'd0);

    // Overrun: frames arriving mid-stream are dropped and counted, buffer untouched.
    load_frame(0, 1'b1);
    wait_idx(7);
    load_frame(55, 1'b0);
    check("ovr_drop1", 32'(drop_count), 32'd1);
    check("ovr_sat1", 32'(s_drop), 32'd1);
    check("ovr_index", 32'(bin_index), 32'd8);
    bin_ready = 1'b0;
    fft_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
    end
    fft_valid = 1'b0;
    bin_ready = 1'b1;
    check("ovr_drop7", 32'(drop_count), 32'd7);
    check("ovr_sat3", 32'(s_drop), 32'd3);
    wait_idle();

    // Reset mid-frame with the sink ready.
    load_frame(0, 1'b1);
    wait_idx(RST_IDX);
    rst = 1'b0;
    #1;
    check("mrst_valid", 32'(bin_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_last", 32'(bin_last), 32'd0);
    check("mrst_data", bin_data, 32'd0);
    check("mrst_index", 32'(bin_index), 32'd0);
    check("mrst_drop", 32'(drop_count), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame(0, -1, 0, cycles);
    check("post_rst_cycles", 32'(cycles), 32'(LAST + 1));

    @(posedge clk); #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
